// File: rtl/matrix_loader10_if.sv
// Stream and multiplier-side bus of the 10x10 matrix loader.
// The slave side is the loader; the master side is its environment.
interface matrix_loader10_if #(
  parameter int N = 10,
  parameter int W = 8
);
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N*N*W-1:0] A;
  logic [N*N*W-1:0] B;
  logic             enable_multiplication;
  logic             mult_done;

  modport master (
    output in_data, in_valid, mult_done,
    input  in_ready, A, B, enable_multiplication
  );

  modport slave (
    input  in_data, in_valid, mult_done,
    output in_ready, A, B, enable_multiplication
  );
endinterface

// File: rtl/matrix_loader10.sv
// Byte-serial loader packing A then B row-major, then driving the multiplier
// enable for a fixed window and flagging a missing mult_done.
module matrix_loader10 #(
  parameter int N             = 10,
  parameter int W             = 8,
  parameter int ENABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  matrix_loader10_if.slave  bus,
  output logic              frame_done,
  output logic              mult_err,
  output logic [6:0]        elem_idx
);
  localparam int              SLOTS    = N * N;
  localparam logic [6:0]      LAST     = 7'(SLOTS - 1);
  localparam int              CW       = $clog2(ENABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ENABLE_CYCLES - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DONE} state_t;

  state_t             state;
  logic [SLOTS*W-1:0] a_q;
  logic [SLOTS*W-1:0] b_q;
  logic               en_q;
  logic               seen;
  logic [CW-1:0]      cnt;
  logic               xfer;

  assign bus.in_ready              = (state == LOAD_A) || (state == LOAD_B);
  assign bus.A                     = a_q;
  assign bus.B                     = b_q;
  assign bus.enable_multiplication = en_q;
  assign xfer                      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      elem_idx   <= '0;
      en_q       <= 1'b0;
      frame_done <= 1'b0;
      mult_err   <= 1'b0;
      cnt        <= '0;
      seen       <= 1'b0;
    end else if (clear) begin
      // Operand registers deliberately survive an abort; a dropped byte is lost.
      state      <= LOAD_A;
      elem_idx   <= '0;
      en_q       <= 1'b0;
      frame_done <= 1'b0;
      mult_err   <= 1'b0;
      cnt        <= '0;
      seen       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        LOAD_A, LOAD_B: begin
          if (xfer) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
              if (elem_idx == 7'(k)) begin
                if (state == LOAD_A) a_q[k*W +: W] <= bus.in_data;
                else                 b_q[k*W +: W] <= bus.in_data;
              end
            end
            if (elem_idx == LAST) begin
              elem_idx <= '0;
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                state <= COMPUTE;
                en_q  <= 1'b1;
                cnt   <= '0;
              end
            end else begin
              elem_idx <= elem_idx + 7'd1;
            end
          end
        end
        COMPUTE: begin
          if (bus.mult_done) seen <= 1'b1;
          if (cnt == CNT_LAST) begin
            // frame_done is raised here so it coincides with the DONE cycle.
            en_q       <= 1'b0;
            cnt        <= '0;
            state      <= DONE;
            frame_done <= 1'b1;
            if (!(seen || bus.mult_done)) mult_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          seen  <= 1'b0;
          state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_loader10.sv
// Scoreboard bench for matrix_loader10: expected operand frames are queued
// when a frame is driven and compared when frame_done pulses.
module tb_matrix_loader10;
  localparam int N  = 10;
  localparam int W  = 8;
  localparam int EC = 2;
  localparam int NB = N * N * W;

  typedef struct packed {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       frame_done;
  logic       mult_err;
  logic [6:0] elem_idx;
  logic       md_reg;
  logic       md_force;
  logic       tie_ok;

  int errors = 0;
  int checks = 0;

  logic [7:0] a_data [100];
  logic [7:0] b_data [100];
  frame_t     sb [$];

  matrix_loader10_if #(.N(N), .W(W)) bus ();

  matrix_loader10 #(.N(N), .W(W), .ENABLE_CYCLES(EC)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus),
    .frame_done (frame_done),
    .mult_err   (mult_err),
    .elem_idx   (elem_idx)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: acknowledges one cycle into the enable window.
  always @(posedge clk) md_reg <= tie_ok & bus.enable_multiplication;
  assign bus.mult_done = md_reg | md_force;

  task automatic check_val(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_pattern(input int p);
    for (int k = 0; k < 100; k++) begin
      case (p)
        0: begin a_data[k] = ((k / 10) == (k % 10)) ? 8'h01 : 8'h00; b_data[k] = 8'(k); end
        1: begin a_data[k] = 8'(k * 3 + 7); b_data[k] = 8'(255 - k); end
        default: begin a_data[k] = 8'(k) ^ 8'h5A; b_data[k] = 8'(k * 7); end
      endcase
    end
  endtask

  task automatic push_expected();
    frame_t f;
    for (int k = 0; k < 100; k++) begin
      f.a[k*8 +: 8] = a_data[k];
      f.b[k*8 +: 8] = b_data[k];
    end
    sb.push_back(f);
  endtask

  // Sends global bytes [start, start+count) of the 200-byte frame.
  task automatic load_range(input int start, input int count, input bit gaps);
    for (int k = start; k < start + count; k++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
          check_val("rdy_gap", NB'(bus.in_ready), NB'(1));
        end
      end
      bus.in_data  = (k < 100) ? a_data[k] : b_data[k - 100];
      bus.in_valid = 1'b1;
      if (k != 199) check_val("rdy_load", NB'(bus.in_ready), NB'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check_val("idx", NB'(elem_idx), NB'((k + 1) % 100));
    end
  endtask

  // Called one step after the edge accepting the final B byte.
  task automatic run_compute(input bit exp_err);
    int rl = 0;
    int eh = 0;
    int fd = 0;
    frame_t f;
    check_val("en_latency", NB'(bus.enable_multiplication), NB'(1));
    for (int c = 0; c < 20 && !bus.in_ready; c++) begin
      rl++;
      if (bus.enable_multiplication) eh++;
      if (frame_done) begin
        fd++;
        check_val("err_at_done", NB'(mult_err), NB'(exp_err));
        if (sb.size() == 0) begin
          check_val("sb_empty", NB'(1), NB'(0));
        end else begin
          f = sb.pop_front();
          check_val("A", bus.A, f.a);
          check_val("B", bus.B, f.b);
        end
      end
      @(posedge clk); #1;
    end
    check_val("rdy_back", NB'(bus.in_ready), NB'(1));
    check_val("rdy_low_cycles", NB'(rl), NB'(EC + 1));
    check_val("en_cycles", NB'(eh), NB'(EC));
    check_val("fd_pulses", NB'(fd), NB'(1));
    check_val("fd_after", NB'(frame_done), NB'(0));
  endtask

  task automatic full_frame(input bit gaps, input bit exp_err);
    push_expected();
    load_range(0, 200, gaps);
    run_compute(exp_err);
  endtask

  initial begin
    logic [7:0] prev_b49;
    int en_seen;
    rst = 1'b1; clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    md_force = 1'b0; tie_ok = 1'b1;
    #1;
    check_val("rst_A", bus.A, '0);
    check_val("rst_B", bus.B, '0);
    check_val("rst_idx", NB'(elem_idx), NB'(0));
    check_val("rst_en", NB'(bus.enable_multiplication), NB'(0));
    check_val("rst_fd", NB'(frame_done), NB'(0));
    check_val("rst_err", NB'(mult_err), NB'(0));
    check_val("rst_rdy", NB'(bus.in_ready), NB'(1));
    #6 rst = 1'b0;

    // Identity A, ramp B, no gaps.
    set_pattern(0);
    full_frame(1'b0, 1'b0);
    for (int i = 0; i < N; i++) check_val("A_diag", NB'(bus.A[(i*N+i)*8 +: 8]), NB'(1));
    check_val("B_57", NB'(bus.B[57*8 +: 8]), NB'(8'h39));
    check_val("err_ok", NB'(mult_err), NB'(0));

    // Same data with random gaps, then a different frame back-to-back.
    full_frame(1'b1, 1'b0);
    set_pattern(1);
    full_frame(1'b0, 1'b0);

    // No acknowledge inside the window; stray mult_done during A load is ignored.
    set_pattern(2);
    tie_ok = 1'b0;
    push_expected();
    md_force = 1'b1;
    load_range(0, 100, 1'b0);
    md_force = 1'b0;
    load_range(100, 100, 1'b0);
    run_compute(1'b1);
    check_val("err_sticky", NB'(mult_err), NB'(1));
    tie_ok = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_val("err_cleared", NB'(mult_err), NB'(0));

    // Async reset after 130 accepts, then reload.
    set_pattern(1);
    load_range(0, 130, 1'b0);
    check_val("idx_130", NB'(elem_idx), NB'(30));
    #3 rst = 1'b1;
    #1;
    check_val("arst_A", bus.A, '0);
    check_val("arst_B", bus.B, '0);
    check_val("arst_idx", NB'(elem_idx), NB'(0));
    #2 rst = 1'b0;
    set_pattern(2);
    full_frame(1'b1, 1'b0);

    // clear coincident with the 150th accept drops that byte.
    prev_b49 = b_data[49];
    set_pattern(1);
    load_range(0, 149, 1'b0);
    bus.in_data = 8'hC3; bus.in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; clear = 1'b0;
    check_val("clr_idx", NB'(elem_idx), NB'(0));
    check_val("clr_rdy", NB'(bus.in_ready), NB'(1));
    check_val("clr_B49", NB'(bus.B[49*8 +: 8]), NB'(prev_b49));
    en_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.enable_multiplication) en_seen++;
      @(posedge clk); #1;
    end
    check_val("clr_no_en", NB'(en_seen), NB'(0));
    full_frame(1'b0, 1'b0);

    check_val("sb_drained", NB'(sb.size()), NB'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
